// File: rtl/perf_dump_tx.sv
// Snapshots NUM_CNT 32-bit perf counters on trigger and streams them as a framed byte sequence (header, little-endian words).
// Optional trailing mod-256 payload checksum byte when PERF_DUMP_CHECKSUM_EN is defined.
module perf_dump_tx #(
   parameter int           NUM_CNT = 6,
   parameter logic [7:0]   HEADER  = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   trigger,
   input  logic [32*NUM_CNT-1:0]  counters_in,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

   localparam int WW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(NUM_CNT - 1);

`ifdef PERF_DUMP_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, HDR, DATA, CKSUM} state_t;
   logic [7:0] cksum;
`else
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

   state_t        state, state_nxt;
   logic [31:0]   snap [NUM_CNT];
   logic [WW-1:0] word_idx, word_nxt;
   logic [1:0]    byte_idx, byte_nxt;
   logic [31:0]   cur_word;
   logic [7:0]    data_byte;
   logic          last_byte;

   assign cur_word  = snap[word_idx];
   assign last_byte = (word_idx == LAST_WORD) && (byte_idx == 2'd3);
   assign busy      = (state != IDLE);

   always_comb begin
      data_byte = cur_word[7:0];
      case (byte_idx)
         2'd1:    data_byte = cur_word[15:8];
         2'd2:    data_byte = cur_word[23:16];
         2'd3:    data_byte = cur_word[31:24];
         default: data_byte = cur_word[7:0];
      endcase
   end

   // tx_valid/tx_data come from state only; tx_ready just gates the advance.
   always_comb begin
      state_nxt = state;
      word_nxt  = word_idx;
      byte_nxt  = byte_idx;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      case (state)
         IDLE: begin
            if (trigger) state_nxt = HDR;
         end
         HDR: begin
            tx_valid = 1'b1;
            tx_data  = HEADER;
            if (tx_ready) begin
               state_nxt = DATA;
               word_nxt  = '0;
               byte_nxt  = 2'd0;
            end
         end
         DATA: begin
            tx_valid = 1'b1;
            tx_data  = data_byte;
            if (tx_ready) begin
               byte_nxt = byte_idx + 2'd1;
               if (last_byte) begin
                  word_nxt = '0;
`ifdef PERF_DUMP_CHECKSUM_EN
                  state_nxt = CKSUM;
`else
                  state_nxt = IDLE;
`endif
               end else if (byte_idx == 2'd3) begin
                  word_nxt = word_idx + 1'b1;
               end
            end
         end
`ifdef PERF_DUMP_CHECKSUM_EN
         CKSUM: begin
            tx_valid = 1'b1;
            tx_data  = cksum;
            if (tx_ready) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word_idx <= '0;
         byte_idx <= 2'd0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         for (int i = 0; i < NUM_CNT; i++) snap[i] <= 32'h0;
`ifdef PERF_DUMP_CHECKSUM_EN
         cksum    <= 8'h00;
`endif
      end else begin
         state    <= state_nxt;
         word_idx <= word_nxt;
         byte_idx <= byte_nxt;
         done     <= (state != IDLE) && (state_nxt == IDLE);
         if (trigger) begin
            if (state == IDLE) begin
               overrun <= 1'b0;
               for (int i = 0; i < NUM_CNT; i++) snap[i] <= counters_in[32*i +: 32];
`ifdef PERF_DUMP_CHECKSUM_EN
               cksum <= 8'h00;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end
`ifdef PERF_DUMP_CHECKSUM_EN
         if (state == DATA && tx_ready) cksum <= cksum + data_byte;
`endif
      end
   end

endmodule

// File: tb/tb_perf_dump_tx.sv
// Bench for perf_dump_tx: queue-based frame model checked every cycle, plus hand-computed byte checks.
module tb_perf_dump_tx;
   localparam int N = 6;
`ifdef PERF_DUMP_CHECKSUM_EN
   localparam int FLEN = 2 + 4*N;
`else
   localparam int FLEN = 1 + 4*N;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           trigger = 1'b0;
   logic           tx_ready = 1'b0;
   logic [32*N-1:0] counters_in = '0;
   logic [7:0]     tx_data;
   logic           tx_valid, busy, done, overrun;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   perf_dump_tx #(.NUM_CNT(N), .HEADER(8'hA5)) dut (
      .clk(clk), .reset(reset), .trigger(trigger), .counters_in(counters_in),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .overrun(overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is just the queue of bytes still owed to the receiver.
   logic [7:0] m_q[$];
   logic       m_done = 1'b0;
   logic       m_ovr  = 1'b0;
   logic       m_busy;
   logic [7:0] m_sum;

   always @(posedge clk) begin
      m_busy = (m_q.size() > 0);
      if (reset) begin
         m_q.delete();
         m_done = 1'b0;
         m_ovr  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_busy && tx_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1'b1;
         end
         if (trigger) begin
            if (m_busy) m_ovr = 1'b1;
            else begin
               m_ovr = 1'b0;
               m_sum = 8'h00;
               m_q.push_back(8'hA5);
               for (int i = 0; i < N; i++)
                  for (int b = 0; b < 4; b++) begin
                     m_q.push_back(counters_in[32*i + 8*b +: 8]);
                     m_sum = m_sum + counters_in[32*i + 8*b +: 8];
                  end
`ifdef PERF_DUMP_CHECKSUM_EN
               m_q.push_back(m_sum);
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() > 0});
         check("tx_data",  {24'd0, tx_data},  {24'd0, (m_q.size() > 0) ? m_q[0] : 8'h00});
         check("busy",     {31'd0, busy},     {31'd0, m_q.size() > 0});
         check("done",     {31'd0, done},     {31'd0, m_done});
         check("overrun",  {31'd0, overrun},  {31'd0, m_ovr});
      end
   end

   logic [7:0] log_q[$];
   always @(negedge clk) if (!reset && tx_valid && tx_ready) log_q.push_back(tx_data);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
   endtask

   // Returns in the done cycle; n is the cycle number counted from the capture edge.
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   logic [7:0] exp_basic [26] = '{8'hA5,
      8'h1E, 8'h00, 8'h00, 8'h00,  8'h19, 8'h00, 8'h00, 8'h00,
      8'h05, 8'h00, 8'h00, 8'h00,  8'h02, 8'h00, 8'h00, 8'h00,
      8'h28, 8'h00, 8'h00, 8'h00,  8'h14, 8'h00, 8'h00, 8'h00, 8'h7A};

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int k;
      reset = 1'b1;
      tick();
      tick();
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data",  {24'd0, tx_data},  32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_done",     {31'd0, done},     32'd0);
      check("rst_overrun",  {31'd0, overrun},  32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;
      tick();

      // Basic dump at full rate
      counters_in = {32'd20, 32'd40, 32'd2, 32'd5, 32'd25, 32'd30};
      tx_ready = 1'b1;
      log_q.delete();
      pulse();
      wait_done(n);
      check("basic_done_cycle", n, FLEN + 1);
      check("basic_len", log_q.size(), FLEN);
      for (int i = 0; i < FLEN; i++)
         if (i < log_q.size()) check("basic_byte", {24'd0, log_q[i]}, {24'd0, exp_basic[i]});
      tick();

      // Backpressure: ready toggles every cycle
      counters_in[31:0] = 32'h12345678;
      tx_ready = 1'b0;
      log_q.delete();
      pulse();
      for (k = 0; k < 400; k++) begin
         if (done) break;
         tx_ready = ~tx_ready;
         tick();
      end
      check("bp_done_seen", {31'd0, done}, 32'd1);
      check("bp_len", log_q.size(), FLEN);
      if (log_q.size() >= 5) begin
         check("bp_b0", {24'd0, log_q[0]}, 32'hA5);
         check("bp_b1", {24'd0, log_q[1]}, 32'h78);
         check("bp_b2", {24'd0, log_q[2]}, 32'h56);
         check("bp_b3", {24'd0, log_q[3]}, 32'h34);
         check("bp_b4", {24'd0, log_q[4]}, 32'h12);
      end
      tx_ready = 1'b1;
      tick();

      // Snapshot stability and overrun
      for (int i = 0; i < N; i++) counters_in[32*i +: 32] = 32'h0A0B0C00 + i;
      log_q.delete();
      pulse();
      for (k = 1; k < 400; k++) begin
         if (done) break;
         for (int i = 0; i < N; i++) counters_in[32*i +: 32] = counters_in[32*i +: 32] + 32'd1;
         trigger = (k == 4);
         if (k == 10) check("ovr_mid", {31'd0, overrun}, 32'd1);
         tick();
      end
      trigger = 1'b0;
      check("ovr_at_done", {31'd0, overrun}, 32'd1);
      check("snap_len", log_q.size(), FLEN);
      if (log_q.size() >= 1 + 4*N)
         for (int i = 0; i < N; i++) begin
            check("snap_w_b0", {24'd0, log_q[1+4*i]}, i);
            check("snap_w_b1", {24'd0, log_q[2+4*i]}, 32'h0C);
            check("snap_w_b2", {24'd0, log_q[3+4*i]}, 32'h0B);
            check("snap_w_b3", {24'd0, log_q[4+4*i]}, 32'h0A);
         end
      tick();
      pulse();
      check("ovr_cleared", {31'd0, overrun}, 32'd0);
      wait_done(n);
      tick();

      // Reset mid-frame, with overrun pending
      pulse();
      for (k = 1; k < 10; k++) begin
         trigger = (k == 3);
         tick();
      end
      trigger = 1'b0;
      check("pre_rst_ovr", {31'd0, overrun}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
      check("mid_rst_busy",  {31'd0, busy},     32'd0);
      check("mid_rst_done",  {31'd0, done},     32'd0);
      check("mid_rst_ovr",   {31'd0, overrun},  32'd0);
      log_q.delete();
      pulse();
      wait_done(n);
      check("post_rst_cycle", n, FLEN + 1);
      check("post_rst_len", log_q.size(), FLEN);
      if (log_q.size() > 0) check("post_rst_hdr", {24'd0, log_q[0]}, 32'hA5);
      tick();

      // Back-to-back: second trigger in the done cycle
      for (int i = 0; i < N; i++) counters_in[32*i +: 32] = i + 1;
      log_q.delete();
      pulse();
      wait_done(n);
      for (int i = 0; i < N; i++) counters_in[32*i +: 32] = 32'h01010101;
      pulse();
      check("b2b_valid", {31'd0, tx_valid}, 32'd1);
      check("b2b_hdr",   {24'd0, tx_data},  32'hA5);
      wait_done(n);
      check("b2b_cycle", n, FLEN + 1);
      check("b2b_len", log_q.size(), 2*FLEN);
      if (log_q.size() == 2*FLEN) begin
         check("b2b_hdr2", {24'd0, log_q[FLEN]}, 32'hA5);
`ifdef PERF_DUMP_CHECKSUM_EN
         check("b2b_ck1", {24'd0, log_q[FLEN-1]},   32'h15);
         check("b2b_ck2", {24'd0, log_q[2*FLEN-1]}, 32'h18);
`else
         check("b2b_last1", {24'd0, log_q[FLEN-4]},   32'h06);
         check("b2b_last2", {24'd0, log_q[2*FLEN-1]}, 32'h01);
`endif
      end
      tick();
      tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/perf_dump_tx.md
Name: perf_dump_tx

Overview:
- Hardware counterpart to bench-side readout of CPU performance counters. On FPGA there is no $display, so this block is the on-chip transmitter for those values.
- On a trigger, it snapshots the CPU event counters: cycle, instr, mem_read, mem_write, rf_read, rf_write.
- It serializes the snapshot into a framed byte stream over a valid/ready interface.
- The stream feeds the board UART transmitter; a host-side reader decodes the frame.

Parameters:
- NUM_CNT, 6, number of 32-bit counters in the frame; must be >= 1.
- HEADER, 8'hA5, sync byte that opens every frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  single-cycle dump request.
- counters_in  input  32*NUM_CNT  flattened counters; counter 0 in bits [31:0]. Order: cycle, instr, mem_read, mem_write, rf_read, rf_write.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts a byte when tx_valid && tx_ready at a rising clk edge.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last byte is accepted.
- overrun  output  1  sticky: a trigger arrived while busy.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, busy=0, done=0, overrun=0, snapshot=0, state=IDLE, byte/word indices=0.
- Reset mid-frame abandons the partial frame. Outputs return to reset values at the first edge with reset high. No resumption.
- States: IDLE, HDR, DATA, CKSUM (present only with the optional feature).
- IDLE:
  - trigger=1 at edge N: capture all of counters_in into the snapshot, clear overrun, go to HDR.
  - In cycle N+1: tx_valid=1, tx_data=HEADER, busy=1.
- HDR: on handshake, go to DATA with word=0, byte=0.
- DATA:
  - tx_data = snapshot word[word], byte[byte], little-endian (bits [7:0] first).
  - On handshake: byte increments. After byte 3, byte wraps to 0 and word increments.
  - After the handshake of word NUM_CNT-1, byte 3: go to CKSUM if enabled, else IDLE.
- CKSUM: on handshake, go to IDLE.
- Entry to IDLE from a frame: tx_valid=0, busy=0, done=1 for exactly one cycle.
- Handshake rules:
  - tx_valid stays high, and tx_data stays stable, until tx_ready is sampled high.
  - tx_valid never depends combinationally on tx_ready.
  - No bubbles when tx_ready is held high: one byte per cycle.
- Frame length: 1 + 4*NUM_CNT bytes, plus 1 with checksum. Defaults: 25 or 26 bytes.
- Throughput: minimum trigger-to-trigger period = frame length + 1 cycles. A trigger in the done cycle is accepted (state is IDLE).
- Snapshot holds constant for the whole frame. Live counter changes after the capture edge do not affect the frame.
- Trigger while busy:
  - Ignored; no frame is queued.
  - overrun is set at that edge and holds until the next accepted trigger.
  - A trigger coinciding with the final handshake edge is also ignored and sets overrun.
- tx_ready may toggle arbitrarily. Stalls of any length are legal. tx_ready is don't-care when tx_valid=0.

Optional Feature:
- Macro: PERF_DUMP_CHECKSUM_EN.
- Defined:
  - CKSUM state exists.
  - After the last data byte, the block sends one byte: the sum mod 256 of all payload bytes. The header is excluded.
  - The accumulator clears on trigger acceptance and adds each data byte at its handshake.
- Undefined:
  - No CKSUM state and no accumulator logic.
  - The frame ends after the last data byte.

Test Plan:
- Basic dump, tx_ready=1, checksum on:
  - counters = 30, 25, 5, 2, 40, 20; pulse trigger.
  - Byte stream starts the cycle after trigger: A5, 1E 00 00 00, 19 00 00 00, 05 00 00 00, 02 00 00 00, 28 00 00 00, 14 00 00 00, 7A.
  - 26 consecutive cycles; done pulses on cycle 27.
- Same stimulus with the macro undefined:
  - Identical first 25 bytes, no 7A.
  - done on cycle 26.
- Backpressure:
  - tx_ready alternates 0/1 each cycle; counter0 = 32'h12345678.
  - Bytes after A5 are 78 56 34 12.
  - tx_data is stable through every stall; no byte is lost or duplicated.
- Snapshot and overrun:
  - Counters increment every cycle after the trigger; re-pulse trigger at byte 5.
  - Frame carries the values from the trigger edge only.
  - overrun=1 and stays 1; a second frame starts only after done.
  - A trigger after done clears overrun.
- Reset mid-frame:
  - Assert reset during byte 10 for 1 cycle.
  - Next edge: tx_valid=0, busy=0, done=0, overrun=0.
  - A new trigger produces a complete frame starting with A5.
- Back-to-back:
  - Trigger asserted in the done cycle, tx_ready=1.
  - Second frame's A5 appears on the following cycle.
  - Both frames are correct, with checksums matching their own snapshots.
